mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-ported, variable-latency memory between the CPU's instruction-fetch port and its stage-3 load/store port. It serializes one transaction at a time and gives data accesses priority, with a starvation guard for fetch. It returns read data and per-port completion pulses, drives a pipeline `stall`, and flags memory that never responds.

---
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes fetch and data accesses onto one variable-latency memory port
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_size,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        timeout_err
);
  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  localparam logic [7:0] TL = 8'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic owner;
  logic [3:0] starve_cnt;
  logic [7:0] tmo_cnt;
  logic f, d, win_if, win_dm, done, tmo;
  logic [31:0] rsp;
  assign f = if_req & ~if_valid;
  assign d = dm_req & ~dm_valid;
  assign win_if = f & (~d | (starve_cnt == SL));
  assign win_dm = d & ~win_if;
  assign done = (state == WAIT) & mem_rvalid;
  assign tmo = (state != IDLE) & ~done & (tmo_cnt == TL);
  assign rsp = tmo ? 32'hDEAD_BEEF : (owner & mem_we) ? 32'h0 : mem_rdata;
  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (f | d) ? REQ : IDLE;
    else if (done | tmo) state_n = IDLE;
    else if (state == REQ && mem_gnt) state_n = WAIT;
  end
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_size    <= '0;
      if_rdata    <= '0;
      if_valid    <= 1'b0;
      dm_rdata    <= '0;
      dm_valid    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_n;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (state == IDLE) begin
        tmo_cnt    <= '0;
        starve_cnt <= (!f || win_if) ? 4'd0 : starve_cnt + {3'd0, starve_cnt != SL};
        if (f | d) begin
          owner     <= win_dm;
          mem_req   <= 1'b1;
          mem_we    <= win_dm & dm_we;
          mem_addr  <= win_dm ? dm_addr : if_addr;
          mem_wdata <= win_dm ? dm_wdata : 32'h0;
          mem_size  <= win_dm ? dm_size : 3'b010;
        end
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
        if ((state == REQ && mem_gnt) || tmo) mem_req <= 1'b0;
        if (done | tmo) begin
          if_valid    <= ~owner;
          dm_valid    <= owner;
          timeout_err <= timeout_err | tmo;
          if (owner) dm_rdata <= rsp;
          else if_rdata <= rsp;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized run against a reference model
module tb_mem_port_arbiter;
  localparam int TMO = 8;
  logic CLK = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [2:0] dm_size = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_valid, dm_valid, mem_req, mem_we, stall, timeout_err;
  logic [2:0] mem_size;
  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall(stall), .timeout_err(timeout_err)
  );
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;
  typedef struct {
    logic ifr; logic [31:0] ifa; logic dmr, dmw; logic [31:0] dma, dmd; logic [2:0] dms;
    logic g, rv; logic [31:0] rd;
    logic x_req, x_we; logic [31:0] x_addr, x_wd; logic [2:0] x_sz; logic x_ifv, x_dmv; logic [31:0] x_rd; logic x_stall;
  } vec_t;
  vec_t tbl[12];
  logic owners[6];
  bit busy, gotg, own_dm, wf, fr, dr, lg;
  int starve, start, k;
  logic e_req, e_we, e_ifv, e_dmv, e_err;
  logic [31:0] e_addr, e_wdata, e_ifrd, e_dmrd, v;
  logic [2:0] e_size;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic mem_in(input logic g, input logic rv, input logic [31:0] rd);
    mem_gnt = g;
    mem_rvalid = rv;
    mem_rdata = rd;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 3'd2, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[3]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h00500093, 1'b0};
    for (int i = 4; i < 10; i++)
      tbl[i] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, (i == 8), 1'b0, 32'h0,
                 (i >= 5 && i <= 8), 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, 1'b0, 1'b0, 32'h0, 1'b1};
    tbl[9].rv = 1'b1;
    tbl[9].rd = 32'h12345678;
    tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0};
    cyc();
    cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we_size", {mem_we, mem_size}, 0);
    chk("rst_valids", {if_valid, dm_valid, timeout_err}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    chk("rst_stall_lo", stall, 0);
    if_req = 1'b1;
    #1;
    chk("rst_stall_hi", stall, 1);
    if_req = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if_req = tbl[i].ifr; if_addr = tbl[i].ifa; dm_req = tbl[i].dmr; dm_we = tbl[i].dmw;
      dm_addr = tbl[i].dma; dm_wdata = tbl[i].dmd; dm_size = tbl[i].dms;
      mem_in(tbl[i].g, tbl[i].rv, tbl[i].rd);
      #1;
      chk($sformatf("v%0d_mem_req", i), mem_req, tbl[i].x_req);
      if (tbl[i].x_req) begin
        chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].x_we);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].x_addr);
        chk($sformatf("v%0d_mem_size", i), mem_size, tbl[i].x_sz);
        if (tbl[i].x_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].x_wd);
      end
      chk($sformatf("v%0d_if_valid", i), if_valid, tbl[i].x_ifv);
      chk($sformatf("v%0d_dm_valid", i), dm_valid, tbl[i].x_dmv);
      if (tbl[i].x_ifv) chk($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].x_rd);
      if (tbl[i].x_dmv) chk($sformatf("v%0d_dm_rdata", i), dm_rdata, tbl[i].x_rd);
      chk($sformatf("v%0d_stall", i), stall, tbl[i].x_stall);
    end
    cyc();
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_size = 3'd0;
    mem_in(1'b0, 1'b0, 32'h0);
    #1;
    chk("pri_req0", mem_req, 0);
    cyc(); mem_in(1'b1, 1'b0, 32'h0); #1;
    chk("pri_req1", mem_req, 1);
    chk("pri_addr_dm", mem_addr, 32'h2000);
    chk("pri_we", mem_we, 0);
    cyc(); mem_in(1'b0, 1'b1, 32'hAAAA5555); #1;
    chk("pri_req2", mem_req, 0);
    cyc(); mem_in(1'b0, 1'b0, 32'h0); dm_req = 1'b0; #1;
    chk("pri_dm_valid", dm_valid, 1);
    chk("pri_dm_rdata", dm_rdata, 32'hAAAA5555);
    chk("pri_if_valid0", if_valid, 0);
    chk("pri_req3", mem_req, 0);
    cyc(); mem_in(1'b1, 1'b0, 32'h0); #1;
    chk("pri_if_req", mem_req, 1);
    chk("pri_if_addr", mem_addr, 32'h200);
    chk("pri_no_dup", dm_valid, 0);
    cyc(); mem_in(1'b0, 1'b1, 32'h11112222); #1;
    cyc(); mem_in(1'b0, 1'b0, 32'h0); if_req = 1'b0; #1;
    chk("pri_if_valid", if_valid, 1);
    chk("pri_if_rdata", if_rdata, 32'h11112222);
    cyc();
    if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_addr = 32'h3000;
    lg = 1'b0;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      cyc();
      if (k < 6 && (if_valid || dm_valid)) begin
        owners[k] = dm_valid;
        k++;
        if (k == 6) begin if_req = 1'b0; dm_req = 1'b0; end
      end
      mem_in(mem_req, lg, 32'h0);
      lg = mem_req;
      #1;
    end
    chk("alt_count", k, 6);
    for (int j = 0; j < 6; j++) chk($sformatf("alt_owner%0d", j), owners[j], (j % 2 == 0));
    mem_in(1'b0, 1'b0, 32'h0);
    cyc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    for (int c = 1; c <= TMO + 1; c++) begin
      cyc(); mem_in(c == 1, 1'b0, 32'h0); #1;
      chk($sformatf("tmo_dmv_c%0d", c), dm_valid, 0);
      chk($sformatf("tmo_err_c%0d", c), timeout_err, 0);
    end
    cyc(); dm_req = 1'b0; mem_in(1'b0, 1'b0, 32'h0); #1;
    chk("tmo_dm_valid", dm_valid, 1);
    chk("tmo_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_mem_req", mem_req, 0);
    cyc(); if_req = 1'b1; if_addr = 32'h400; #1;
    cyc(); mem_in(1'b1, 1'b0, 32'h0); #1;
    chk("tmo_next_req", mem_req, 1);
    cyc(); mem_in(1'b0, 1'b1, 32'h5A5A5A5A); #1;
    cyc(); mem_in(1'b0, 1'b0, 32'h0); if_req = 1'b0; #1;
    chk("tmo_next_valid", if_valid, 1);
    chk("tmo_next_rdata", if_rdata, 32'h5A5A5A5A);
    chk("tmo_sticky", timeout_err, 1);
    cyc(); if_req = 1'b1; if_addr = 32'h500; #1;
    cyc(); mem_in(1'b1, 1'b0, 32'h0); #1;
    cyc(); mem_in(1'b0, 1'b0, 32'h0); #2;
    rst = 1'b1;
    #1;
    chk("rw_mem_req", mem_req, 0);
    chk("rw_valids", {if_valid, dm_valid}, 0);
    chk("rw_err", timeout_err, 0);
    chk("rw_mem_addr", mem_addr, 0);
    if_req = 1'b0;
    mem_rvalid = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc(); mem_rvalid = (c == 0); #1;
      chk($sformatf("rw_stale_valid%0d", c), {if_valid, dm_valid}, 0);
      chk($sformatf("rw_idle_req%0d", c), mem_req, 0);
    end
    busy = 0; gotg = 0; starve = 0; start = 0;
    e_req = 0; e_we = 0; e_ifv = 0; e_dmv = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_size = '0; e_ifrd = '0; e_dmrd = '0;
    for (int n = 0; n < 4000; n++) begin
      cyc();
      if (!if_req || e_ifv) begin if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom; end
      if (!dm_req || e_dmv) begin
        dm_req = ($urandom_range(0, 2) != 0); dm_we = 1'($urandom); dm_addr = $urandom;
        dm_wdata = $urandom; dm_size = 3'($urandom);
      end
      mem_in(1'($urandom), gotg ? 1'($urandom) : ($urandom_range(0, 9) == 0), $urandom);
      #1;
      chk("rnd_mem_req", mem_req, e_req);
      if (e_req) begin
        chk("rnd_mem_addr", mem_addr, e_addr);
        chk("rnd_mem_we", mem_we, e_we);
        chk("rnd_mem_size", mem_size, e_size);
        if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
      end
      chk("rnd_if_valid", if_valid, e_ifv);
      chk("rnd_dm_valid", dm_valid, e_dmv);
      if (e_ifv) chk("rnd_if_rdata", if_rdata, e_ifrd);
      if (e_dmv) chk("rnd_dm_rdata", dm_rdata, e_dmrd);
      chk("rnd_err", timeout_err, e_err);
      chk("rnd_stall", stall, (if_req & ~e_ifv) | (dm_req & ~e_dmv));
      fr = if_req & ~e_ifv;
      dr = dm_req & ~e_dmv;
      e_ifv = 0;
      e_dmv = 0;
      if (!busy) begin
        if (fr || dr) begin
          wf = fr && (!dr || starve == 4);
          starve = (!fr || wf) ? 0 : (starve < 4 ? starve + 1 : 4);
          busy = 1; gotg = 0; start = n + 1; own_dm = !wf;
          e_req = 1; e_addr = wf ? if_addr : dm_addr; e_we = !wf && dm_we;
          e_size = wf ? 3'b010 : dm_size; e_wdata = dm_wdata;
        end else starve = 0;
      end else if ((gotg && mem_rvalid) || n - start == TMO) begin
        v = (gotg && mem_rvalid) ? ((own_dm && e_we) ? 32'h0 : mem_rdata) : 32'hDEADBEEF;
        if (!(gotg && mem_rvalid)) e_err = 1;
        busy = 0; e_req = 0;
        if (own_dm) begin e_dmv = 1; e_dmrd = v; end
        else begin e_ifv = 1; e_ifrd = v; end
      end else if (!gotg && mem_gnt) begin
        gotg = 1; e_req = 0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
